telemetry_frame_rx: RTL and testbench
=====================================

// Module: telemetry_frame_rx
// PURPOSE
//  Ground-side UART receiver and frame parser for guidance telemetry. Deserialises 8N1 bytes.
//  Assembles the 4-byte frame {pos_y, pos_x, vel_y, vel_x}, sent in that order.
//  Presents the four fields in parallel with a one-cycle frame_valid strobe.
//  Sits on the host/display FPGA, at the far end of the guidance unit's telemetry UART link.
// PARAMETERS
//  CLK_FREQ      50000000  system clock frequency, Hz
//  BAUD_RATE     9600      line rate, bit/s
//  BAUD_DIV      CLK_FREQ/BAUD_RATE  clocks per bit (localparam, derived)
//  TIMEOUT_BITS  20        inter-byte gap, in bit periods, that aborts a partial frame
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high reset
//  rx           in   1  asynchronous UART line, idle high
//  pos_y        out  8  frame byte 0
//  pos_x        out  8  frame byte 1
//  vel_y        out  8  frame byte 2
//  vel_x        out  8  frame byte 3
//  frame_valid  out  1  1-cycle pulse; all four fields updated this cycle
//  frame_err    out  1  1-cycle pulse on a stop-bit framing error
// BEHAVIOUR
//  Reset
//   - All outputs go to 0; the byte index goes to 0; the FSM goes to IDLE.
//   - Both synchroniser flops go to 1.
//   - Reset mid-byte or mid-frame discards the partial data and emits no pulse.
//  Input
//   - rx passes through a 2-FF synchroniser; rx_s is the synchronised value.
//   - All sampling uses rx_s; 2 cycles of input latency.
//  Bit FSM, driven by a down-counter baud_cnt
//   - IDLE: when rx_s==0, baud_cnt<=BAUD_DIV/2-1 -> START.
//   - START: at baud_cnt==0, sample rx_s.
//     - rx_s==1 is a false start -> IDLE; no pulse, byte index unchanged.
//     - rx_s==0: baud_cnt<=BAUD_DIV-1, bit_cnt<=0 -> DATA.
//   - DATA: at each baud_cnt==0, shift rx_s in LSB-first and reload BAUD_DIV-1.
//     - After the 8th bit -> STOP.
//   - STOP: at baud_cnt==0, sample rx_s.
//     - rx_s==1: byte accepted -> IDLE.
//     - rx_s==0: frame_err pulse, byte discarded, byte index<=0 -> WAIT_HIGH.
//   - WAIT_HIGH: stay until rx_s==1 -> IDLE. This prevents a held break from retriggering.
//  Frame assembly
//   - Accepted bytes are staged by index: 0->y, 1->x, 2->vy, 3->vx.
//   - The index increments mod 4.
//   - On acceptance of index 3, all four output registers load together on the same edge.
//     - frame_valid is high for exactly that cycle.
//     - Latency: 1 cycle after the stop-bit mid-sample of byte 3.
//   - Outputs hold their values between frames and never show a partial frame.
//   - Back-to-back bytes with zero idle time are supported. START can be entered on the
//     cycle after the STOP sample if rx_s==0.
//   - frame_valid and frame_err are never high in the same cycle.
// CONFIGURATION
//  FRAME_TIMEOUT_EN defined
//   - gap_cnt clears when each byte is accepted and counts while the byte index !=0 and the FSM is IDLE.
//   - When gap_cnt reaches TIMEOUT_BITS*BAUD_DIV, the byte index resets to 0 and staged bytes are dropped.
//   - No pulse is emitted for a timeout.
//   - A start bit detected on the same cycle as the timeout: the timeout wins, and the new byte becomes index 0.
//  FRAME_TIMEOUT_EN undefined
//   - No gap counter. The byte index realigns only on reset or a framing error.
// TESTING
//  Bench parameters: CLK_FREQ=1600, BAUD_RATE=100 (BAUD_DIV=16) unless stated.
//  1. Frame 0x40,0x80,0x03,0x00 sent 8N1 with 1-bit gaps -> one frame_valid;
//     pos_y=0x40, pos_x=0x80, vel_y=0x03, vel_x=0x00; frame_err stays 0.
//  2. In IDLE, a 4-clock low glitch on rx -> no byte accepted, no frame_err, index stays 0.
//     Then send frame 0x11,0x22,0x33,0x44 -> decoded exactly.
//  3. Byte 0xA5 sent with stop bit 0, then rx held low for 3 bit periods, then released
//     -> one frame_err pulse only. Then send frame 0x01,0x02,0x03,0x04 -> decoded exactly.
//  4. Send 0x10,0x20, idle 25 bit periods, then send 0x30,0x40,0x50,0x60.
//     With FRAME_TIMEOUT_EN -> frame {0x30,0x40,0x50,0x60}.
//     Without it -> frame {0x10,0x20,0x30,0x40}.
//  5. reset pulsed for 1 cycle during the 4th data bit of byte 2 -> outputs all 0 next cycle.
//     A following full frame 0xFF,0x00,0x7F,0x80 decodes exactly.
//  6. Two frames back-to-back with zero idle bits -> two frame_valid pulses,
//     exactly 40*16=640 clocks apart, each carrying its own frame's values.

Source files
------------

// File: rtl/telemetry_frame_rx.sv
// 8N1 UART receiver that assembles 4-byte guidance telemetry frames {pos_y, pos_x, vel_y, vel_x}.
// Optional inter-byte gap timeout is compiled in with `define FRAME_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | counting to the start-bit centre, rejects glitches
// DATA      | sampling 8 data bits LSB-first at bit centres
// STOP      | sampling the stop bit; accept byte or flag framing error
// WAIT_HIGH | after a framing error, hold off until the line returns high
module telemetry_frame_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 9600,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] pos_y,
    output logic [7:0] pos_x,
    output logic [7:0] vel_y,
    output logic [7:0] vel_x,
    output logic       frame_valid,
    output logic       frame_err
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);

    if (BAUD_DIV < 4 || TIMEOUT_BITS < 1) begin : g_bad_params
        $error("telemetry_frame_rx: BAUD_DIV must be >= 4 and TIMEOUT_BITS >= 1");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t           state;
    logic             rx_m;
    logic             rx_s;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [1:0]       idx;
    logic [7:0]       stg0;
    logic [7:0]       stg1;
    logic [7:0]       stg2;

`ifdef FRAME_TIMEOUT_EN
    localparam int GAP_MAX = TIMEOUT_BITS * BAUD_DIV;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);
    logic [GAP_W-1:0] gap_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            idx         <= '0;
            stg0        <= '0;
            stg1        <= '0;
            stg2        <= '0;
            pos_y       <= '0;
            pos_x       <= '0;
            vel_y       <= '0;
            vel_x       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            gap_cnt     <= '0;
`endif
        end else begin
            rx_m        <= rx;
            rx_s        <= rx_m;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        baud_cnt <= HALF_LOAD;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        baud_cnt <= FULL_LOAD;
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else begin
                        shreg    <= {rx_s, shreg[7:1]};
                        baud_cnt <= FULL_LOAD;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else if (rx_s) begin
                        state <= IDLE;
                        idx   <= idx + 2'd1;
                        case (idx)
                            2'd0: stg0 <= shreg;
                            2'd1: stg1 <= shreg;
                            2'd2: stg2 <= shreg;
                            default: begin
                                // Whole frame lands in one edge so readers never see a mix.
                                pos_y       <= stg0;
                                pos_x       <= stg1;
                                vel_y       <= stg2;
                                vel_x       <= shreg;
                                frame_valid <= 1'b1;
                            end
                        endcase
                    end else begin
                        frame_err <= 1'b1;
                        idx       <= '0;
                        state     <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef FRAME_TIMEOUT_EN
            // Placed after the FSM so a timeout overrides idx even if a start bit arrives now.
            if (state == STOP && baud_cnt == '0 && rx_s) begin
                gap_cnt <= '0;
            end else if (state == IDLE && idx != 2'd0) begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt <= '0;
                    idx     <= '0;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_telemetry_frame_rx.sv
// Self-checking bench for telemetry_frame_rx: table-driven frames, hand-written corner
// sequences, and a randomized byte stream checked against a byte-queue frame model.
module tb_telemetry_frame_rx;
    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] pos_y, pos_x, vel_y, vel_x;
    logic       frame_valid, frame_err;

    telemetry_frame_rx #(
        .CLK_FREQ(1600),
        .BAUD_RATE(100),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .pos_y(pos_y),
        .pos_x(pos_x),
        .vel_y(vel_y),
        .vel_x(vel_x),
        .frame_valid(frame_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got_q[$];
    int          got_t[$];
    int          err_cnt = 0;
    bit          both_high = 1'b0;

    always @(negedge clk) begin
        if (frame_valid) begin
            got_q.push_back({pos_y, pos_x, vel_y, vel_x});
            got_t.push_back(cyc);
        end
        if (frame_err) err_cnt++;
        if (frame_valid && frame_err) both_high = 1'b1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 5000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BD) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_frame(input logic [31:0] f, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(f[31-8*k -: 8], 1'b1);
            idle_bits(gap);
        end
    endtask

    task automatic clear_mon();
        #1;
        got_q.delete();
        got_t.delete();
        err_cnt = 0;
    endtask

    // Expect exactly one frame with the given value and no framing errors since clear_mon.
    task automatic expect_one(input string name, input logic [31:0] exp);
        idle_bits(2);
        #1;
        check({name, "_count"}, got_q.size(), 1);
        if (got_q.size() > 0) check({name, "_value"}, got_q[0], exp);
        check({name, "_err"}, err_cnt, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] bytes;
        int          gap;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    logic [31:0] exp_q[$];
    logic [7:0]  stg[$];
    int          exp_err;
    logic [31:0] exp4;
    int          dt;

    initial begin
        vecs[0] = '{"frame_40800300", 32'h4080_0300, 1, 32'h4080_0300};
        vecs[1] = '{"frame_11223344_g0", 32'h1122_3344, 0, 32'h1122_3344};
        vecs[2] = '{"frame_01020304_g2", 32'h0102_0304, 2, 32'h0102_0304};
        vecs[3] = '{"frame_ff007f80", 32'hFF00_7F80, 1, 32'hFF00_7F80};
        vecs[4] = '{"frame_zero_g3", 32'h0000_0000, 3, 32'h0000_0000};
        vecs[5] = '{"frame_a5a55a5a", 32'hA5A5_5A5A, 1, 32'hA5A5_5A5A};

        repeat (3) @(negedge clk);
        #1;
        check("reset_fields", {pos_y, pos_x, vel_y, vel_x}, 32'h0);
        check("reset_pulses", {30'h0, frame_valid, frame_err}, 32'h0);
        reset = 1'b0;
        idle_bits(2);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            send_frame(vecs[v].bytes, vecs[v].gap);
            expect_one(vecs[v].name, vecs[v].exp);
        end

        // Short low glitch must be rejected as a false start.
        clear_mon();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        idle_bits(3);
        #1;
        check("glitch_frames", got_q.size(), 0);
        check("glitch_err", err_cnt, 0);
        clear_mon();
        send_frame(32'h1122_3344, 1);
        expect_one("after_glitch", 32'h1122_3344);

        // Bad stop bit followed by a held break: a single error pulse, then realigned.
        clear_mon();
        send_byte(8'hA5, 1'b0);
        repeat (3) send_bit(1'b0);
        idle_bits(2);
        #1;
        check("break_err_count", err_cnt, 1);
        check("break_frames", got_q.size(), 0);
        clear_mon();
        send_frame(32'h0102_0304, 1);
        expect_one("after_break", 32'h0102_0304);

        // Long gap after two bytes.
        clear_mon();
        send_byte(8'h10, 1'b1);
        idle_bits(1);
        send_byte(8'h20, 1'b1);
        idle_bits(25);
        send_frame(32'h3040_5060, 1);
        idle_bits(2);
        #1;
`ifdef FRAME_TIMEOUT_EN
        exp4 = 32'h3040_5060;
`else
        exp4 = 32'h1020_3040;
`endif
        check("gap_count", got_q.size(), 1);
        if (got_q.size() > 0) check("gap_value", got_q[0], exp4);
        pulse_reset();
        idle_bits(2);

        // Reset during the 4th data bit of byte 2.
        clear_mon();
        send_frame(32'h5A5A_5A5A, 1);
        clear_mon();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        pulse_reset();
        rx = 1'b1;
        #1;
        check("midreset_fields", {pos_y, pos_x, vel_y, vel_x}, 32'h0);
        check("midreset_valid", {31'h0, frame_valid}, 32'h0);
        idle_bits(12);
        #1;
        check("midreset_no_pulse", got_q.size() + err_cnt, 0);
        clear_mon();
        send_frame(32'hFF00_7F80, 1);
        expect_one("after_midreset", 32'hFF00_7F80);

        // Two frames with zero idle bits.
        clear_mon();
        send_frame(32'h1234_5678, 0);
        send_frame(32'h9ABC_DEF0, 0);
        idle_bits(2);
        #1;
        check("b2b_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("b2b_first", got_q[0], 32'h1234_5678);
            check("b2b_second", got_q[1], 32'h9ABC_DEF0);
            dt = got_t[1] - got_t[0];
            check("b2b_spacing", dt, 640);
        end
        check("b2b_err", err_cnt, 0);

        // Random byte stream with occasional framing errors vs. a byte-queue frame model.
        clear_mon();
        exp_q.delete();
        stg.delete();
        exp_err = 0;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                send_byte(b, 1'b0);
                repeat ($urandom_range(0, 2)) send_bit(1'b0);
                send_bit(1'b1);
                stg.delete();
                exp_err++;
            end else begin
                send_byte(b, 1'b1);
                idle_bits($urandom_range(0, 3));
                stg.push_back(b);
                if (stg.size() == 4) begin
                    exp_q.push_back({stg[0], stg[1], stg[2], stg[3]});
                    stg.delete();
                end
            end
        end
        idle_bits(2);
        #1;
        check("rand_err_count", err_cnt, exp_err);
        check("rand_frame_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("rand_frame_%0d", i), got_q[i], exp_q[i]);
        end

        check("valid_err_exclusive", {31'h0, both_high}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
